// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Data-memory model for the MEM stage request port. Word array stored
//   big-endian (byte offset 0 = bits 31:24). Reads return the whole word.
//   Writes of 1..4 bytes are merged into the addressed word. Every access takes
//   LATENCY cycles, and DM_Stall_OUT holds the pipeline while an access is
//   in flight. With LATENCY = 0 the memory behaves combinationally: it reads
//   in the same cycle and writes at the current rising edge.
//
// Parameters:
//   ADDR_BITS  word-index width; capacity is 2^ADDR_BITS words
//   LATENCY    cycles an access holds the pipeline (0..15)
//   BASE_ADDR  byte address of word 0 (word aligned)
//
// Ports:
//   CLK                  clock, rising edge
//   RESET                asynchronous active-low reset
//   data_address_2DM     byte address of the access
//   data_write_2DM       right-justified write data
//   data_write_size_2DM  write byte count (0 = 4 bytes)
//   MemRead_2DM          read request
//   MemWrite_2DM         write request (wins when both are asserted)
//   data_read_fDM        read data
//   DM_Stall_OUT         MEM stage must hold
//   DM_Error_OUT         one-cycle pulse on an illegal access
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int          ADDR_BITS = 12,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] data_address_2DM,
   input  logic [31:0] data_write_2DM,
   input  logic [1:0]  data_write_size_2DM,
   input  logic        MemRead_2DM,
   input  logic        MemWrite_2DM,
   output logic [31:0] data_read_fDM,
   output logic        DM_Stall_OUT,
   output logic        DM_Error_OUT
);

   localparam int WORDS = 1 << ADDR_BITS;

   logic [31:0] r_mem [0:WORDS-1];

   logic                 w_req;
   logic [31:2]          w_wordOffset;
   logic                 w_outOfRange;
   logic [ADDR_BITS-1:0] w_index;
   logic                 w_badShape;

   // Merges right-justified write data into a word. Byte lanes off..off+n-1
   // get data bytes n-1..0, with the most significant byte at the lowest offset.
   function automatic logic [31:0] mergeWord(
      input logic [31:0] oldWord,
      input logic [31:0] wdata,
      input logic [1:0]  size,
      input logic [1:0]  off
   );
      logic [31:0] result;
      int n;
      int src;
      result = oldWord;
      n      = (size == 2'd0) ? 4 : int'(size);
      for (int k = 0; k < 4; k++) begin
         if ((k >= int'(off)) && (k < int'(off) + n)) begin
            src = n - 1 - (k - int'(off));
            result[31 - 8*k -: 8] = wdata[8*src +: 8];
         end
      end
      return result;
   endfunction

   // A write is illegal when its bytes run past the end of the word. This also
   // covers a 4-byte write that is not word aligned.
   function automatic logic shapeIllegal(input logic [1:0] size, input logic [1:0] off);
      int n;
      n = (size == 2'd0) ? 4 : int'(size);
      return (int'(off) + n) > 4;
   endfunction

   // BASE_ADDR is word aligned. The subtraction is done on word addresses,
   // and the byte offset comes straight from the address.
   assign w_req        = MemRead_2DM | MemWrite_2DM;
   assign w_wordOffset = data_address_2DM[31:2] - BASE_ADDR[31:2];
   assign w_outOfRange = (w_wordOffset[31:ADDR_BITS+2] != '0);
   assign w_index      = w_wordOffset[ADDR_BITS+1:2];
   assign w_badShape   = shapeIllegal(data_write_size_2DM, data_address_2DM[1:0]);

   generate
      if (LATENCY == 0) begin : g_comb
         // Zero-latency mode: reads are combinational, nothing stalls, and
         // errors are flagged in the same cycle as the request.
         assign data_read_fDM = (!RESET || w_outOfRange) ? 32'h0 : r_mem[w_index];
         assign DM_Stall_OUT  = 1'b0;
         assign DM_Error_OUT  = RESET & w_req &
                                (w_outOfRange | (MemRead_2DM & MemWrite_2DM) |
                                 (MemWrite_2DM & w_badShape));

         // Writes commit at the rising edge that ends the request cycle.
         always_ff @(posedge CLK) begin
            if (RESET && MemWrite_2DM && !w_outOfRange && !w_badShape) begin
               r_mem[w_index] <= mergeWord(r_mem[w_index], data_write_2DM,
                                           data_write_size_2DM, data_address_2DM[1:0]);
            end
         end
      end else begin : g_fsm
         localparam logic [1:0] S_IDLE = 2'd0;
         localparam logic [1:0] S_WAIT = 2'd1;
         localparam logic [1:0] S_DONE = 2'd2;

         logic [1:0]           r_state;
         logic [3:0]           r_count;
         logic [ADDR_BITS-1:0] r_index;
         logic [31:0]          r_data;
         logic [1:0]           r_size;
         logic [1:0]           r_off;
         logic                 r_isWrite;
         logic                 r_drop;
         logic                 r_err;
         logic [31:0]          r_readData;

         logic                 w_enterDone;
         logic                 w_srcRead;
         logic                 w_srcDrop;
         logic [ADDR_BITS-1:0] w_srcIndex;

         // When LATENCY is 1, the edge that accepts the request is also the edge
         // that enters DONE. In that case the read must use the live inputs
         // rather than the latched copies.
         always_comb begin
            w_enterDone = 1'b0;
            w_srcRead   = 1'b0;
            w_srcDrop   = 1'b0;
            w_srcIndex  = r_index;
            if (r_state == S_IDLE) begin
               w_enterDone = w_req && (LATENCY == 1);
               w_srcRead   = !MemWrite_2DM;
               w_srcDrop   = w_outOfRange;
               w_srcIndex  = w_index;
            end else if (r_state == S_WAIT) begin
               w_enterDone = (r_count <= 4'd1);
               w_srcRead   = !r_isWrite;
               w_srcDrop   = r_drop;
            end
         end

         assign DM_Stall_OUT  = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);
         assign DM_Error_OUT  = (r_state == S_DONE) && r_err;
         assign data_read_fDM = r_readData;

         // Request FSM. The request is latched in IDLE and held until DONE.
         // Input changes during WAIT and DONE are ignored. r_drop marks an
         // access that must not touch the array. r_err also covers a
         // read+write collision, which still proceeds as a write.
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               r_state    <= S_IDLE;
               r_count    <= 4'd0;
               r_index    <= '0;
               r_data     <= 32'h0;
               r_size     <= 2'd0;
               r_off      <= 2'd0;
               r_isWrite  <= 1'b0;
               r_drop     <= 1'b0;
               r_err      <= 1'b0;
               r_readData <= 32'h0;
            end else begin
               if (w_enterDone && w_srcRead) begin
                  r_readData <= w_srcDrop ? 32'h0 : r_mem[w_srcIndex];
               end
               case (r_state)
                  S_IDLE: begin
                     if (w_req) begin
                        r_index   <= w_index;
                        r_data    <= data_write_2DM;
                        r_size    <= data_write_size_2DM;
                        r_off     <= data_address_2DM[1:0];
                        r_isWrite <= MemWrite_2DM;
                        r_drop    <= w_outOfRange | (MemWrite_2DM & w_badShape);
                        r_err     <= w_outOfRange | (MemWrite_2DM & w_badShape) |
                                     (MemRead_2DM & MemWrite_2DM);
                        r_count   <= 4'(LATENCY - 1);
                        r_state   <= (LATENCY >= 2) ? S_WAIT : S_DONE;
                     end
                  end
                  S_WAIT: begin
                     r_count <= r_count - 4'd1;
                     if (r_count <= 4'd1) begin
                        r_state <= S_DONE;
                     end
                  end
                  S_DONE: begin
                     r_state <= S_IDLE;
                  end
                  default: begin
                     r_state <= S_IDLE;
                  end
               endcase
            end
         end

         // The write commits at the edge that ends DONE. A reset clears the
         // FSM asynchronously, so an in-flight write never reaches this edge.
         always_ff @(posedge CLK) begin
            if ((r_state == S_DONE) && r_isWrite && !r_drop) begin
               r_mem[r_index] <= mergeWord(r_mem[r_index], r_data, r_size, r_off);
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Purpose:
//   Directed bench for data_mem_responder. It drives one LATENCY=2 instance and
//   one LATENCY=0 instance from a shared clock and reset. Expected words are
//   worked out by hand from the big-endian merge rules.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        CLK;
   logic        RESET;

   logic [31:0] l2Addr, l2Wdata, l2Rdata;
   logic [1:0]  l2Size;
   logic        l2Rd, l2Wr, l2Stall, l2Err;

   logic [31:0] l0Addr, l0Wdata, l0Rdata;
   logic [1:0]  l0Size;
   logic        l0Rd, l0Wr, l0Stall, l0Err;

   int testCount = 0;
   int failCount = 0;

   data_mem_responder #(.ADDR_BITS(6), .LATENCY(2), .BASE_ADDR(32'h0)) u_dutLat2 (
      .CLK                 (CLK),
      .RESET               (RESET),
      .data_address_2DM    (l2Addr),
      .data_write_2DM      (l2Wdata),
      .data_write_size_2DM (l2Size),
      .MemRead_2DM         (l2Rd),
      .MemWrite_2DM        (l2Wr),
      .data_read_fDM       (l2Rdata),
      .DM_Stall_OUT        (l2Stall),
      .DM_Error_OUT        (l2Err)
   );

   data_mem_responder #(.ADDR_BITS(6), .LATENCY(0), .BASE_ADDR(32'h0)) u_dutLat0 (
      .CLK                 (CLK),
      .RESET               (RESET),
      .data_address_2DM    (l0Addr),
      .data_write_2DM      (l0Wdata),
      .data_write_size_2DM (l0Size),
      .MemRead_2DM         (l0Rd),
      .MemWrite_2DM        (l0Wr),
      .data_read_fDM       (l0Rdata),
      .DM_Stall_OUT        (l0Stall),
      .DM_Error_OUT        (l0Err)
   );

   // Free-running clock with a 10-unit period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Safety net so the run always ends, even if the sequence below stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares a 32-bit observation against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Compares a single-bit observation against its expected value.
   task automatic checkBit(input string tag, input logic observed, input logic expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // One LATENCY=2 access: an IDLE request cycle, a WAIT cycle, then DONE.
   // The stall must be high for exactly two cycles. Error and read data are
   // checked in DONE. Garbage on the inputs after acceptance must be ignored.
   task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic expErr,
                                input logic [31:0] expRead);
      @(posedge CLK); #1;
      l2Rd = rd; l2Wr = wr; l2Addr = addr; l2Wdata = data; l2Size = size;
      @(negedge CLK);
      checkBit({tag, " idle stall"}, l2Stall, 1'b1);
      checkBit({tag, " idle err"}, l2Err, 1'b0);
      @(posedge CLK); #1;
      l2Rd = 1'b0; l2Wr = 1'b0; l2Addr = 32'hFFFF_FFFC; l2Wdata = 32'h5A5A_5A5A; l2Size = 2'd1;
      @(negedge CLK);
      checkBit({tag, " wait stall"}, l2Stall, 1'b1);
      checkBit({tag, " wait err"}, l2Err, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      checkBit({tag, " done stall"}, l2Stall, 1'b0);
      checkBit({tag, " done err"}, l2Err, expErr);
      checkOutput({tag, " done rdata"}, l2Rdata, expRead);
   endtask

   // One LATENCY=0 cycle. The inputs are applied after the rising edge and the
   // outputs are sampled at the following falling edge.
   task automatic applyStimulusZero(input string tag, input logic rd, input logic wr,
                                    input logic [31:0] addr, input logic [31:0] data,
                                    input logic [1:0] size, input logic expErr,
                                    input logic chkRead, input logic [31:0] expRead);
      @(posedge CLK); #1;
      l0Rd = rd; l0Wr = wr; l0Addr = addr; l0Wdata = data; l0Size = size;
      @(negedge CLK);
      checkBit({tag, " stall"}, l0Stall, 1'b0);
      checkBit({tag, " err"}, l0Err, expErr);
      if (chkRead) checkOutput({tag, " rdata"}, l0Rdata, expRead);
   endtask

   // Directed sequence: reset values first, then the LATENCY=2 path, an
   // asynchronous reset during a write, and finally the zero-latency instance.
   initial begin
      RESET = 1'b1;
      l2Rd = 1'b0; l2Wr = 1'b0; l2Addr = 32'h0; l2Wdata = 32'h0; l2Size = 2'd0;
      l0Rd = 1'b0; l0Wr = 1'b0; l0Addr = 32'h0; l0Wdata = 32'h0; l0Size = 2'd0;
      #1 RESET = 1'b0;
      #2;
      checkBit("reset stall", l2Stall, 1'b0);
      checkBit("reset err", l2Err, 1'b0);
      checkOutput("reset rdata", l2Rdata, 32'h0);
      checkBit("reset lat0 stall", l0Stall, 1'b0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      applyStimulus("wr full 0x10",    1'b0, 1'b1, 32'h10,  32'h1122_3344, 2'd0, 1'b0, 32'h0);
      applyStimulus("rd 0x10",         1'b1, 1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 32'h1122_3344);
      applyStimulus("wr b1 0x11",      1'b0, 1'b1, 32'h11,  32'h0000_00AA, 2'd1, 1'b0, 32'h1122_3344);
      applyStimulus("rd 0x12",         1'b1, 1'b0, 32'h12,  32'h0,         2'd0, 1'b0, 32'h11AA_3344);
      applyStimulus("wr full 0x14",    1'b0, 1'b1, 32'h14,  32'h0102_0304, 2'd0, 1'b0, 32'h11AA_3344);
      applyStimulus("wr b3 0x15",      1'b0, 1'b1, 32'h15,  32'h00BB_CCDD, 2'd3, 1'b0, 32'h11AA_3344);
      applyStimulus("rd 0x14 a",       1'b1, 1'b0, 32'h14,  32'h0,         2'd0, 1'b0, 32'h01BB_CCDD);
      applyStimulus("wr b2 0x14",      1'b0, 1'b1, 32'h14,  32'h0000_EEFF, 2'd2, 1'b0, 32'h01BB_CCDD);
      applyStimulus("rd 0x14 b",       1'b1, 1'b0, 32'h14,  32'h0,         2'd0, 1'b0, 32'hEEFF_CCDD);
      applyStimulus("wr cross 0x13",   1'b0, 1'b1, 32'h13,  32'h0000_FFFF, 2'd2, 1'b1, 32'hEEFF_CCDD);
      applyStimulus("rd 0x10 after",   1'b1, 1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 32'h11AA_3344);
      applyStimulus("wr unalign 0x16", 1'b0, 1'b1, 32'h16,  32'hFFFF_FFFF, 2'd0, 1'b1, 32'h11AA_3344);
      applyStimulus("rd 0x14 c",       1'b1, 1'b0, 32'h14,  32'h0,         2'd0, 1'b0, 32'hEEFF_CCDD);
      applyStimulus("wr full 0x00",    1'b0, 1'b1, 32'h00,  32'hCAFE_F00D, 2'd0, 1'b0, 32'hEEFF_CCDD);
      applyStimulus("wr oor 0x100",    1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 2'd0, 1'b1, 32'hEEFF_CCDD);
      applyStimulus("rd oor 0x100",    1'b1, 1'b0, 32'h100, 32'h0,         2'd0, 1'b1, 32'h0);
      applyStimulus("rd 0x00",         1'b1, 1'b0, 32'h00,  32'h0,         2'd0, 1'b0, 32'hCAFE_F00D);
      applyStimulus("rd+wr 0x18",      1'b1, 1'b1, 32'h18,  32'h5566_7788, 2'd0, 1'b1, 32'hCAFE_F00D);

      // Reset lands in WAIT of a write. The stall and read data clear
      // immediately, and the write never reaches memory.
      @(posedge CLK); #1;
      l2Rd = 1'b0; l2Wr = 1'b1; l2Addr = 32'h10; l2Wdata = 32'hFFFF_FFFF; l2Size = 2'd0;
      @(negedge CLK);
      checkBit("abort idle stall", l2Stall, 1'b1);
      @(posedge CLK); #1;
      l2Wr = 1'b0; l2Addr = 32'h0; l2Wdata = 32'h0;
      #1 RESET = 1'b0;
      #1;
      checkBit("abort stall", l2Stall, 1'b0);
      checkBit("abort err", l2Err, 1'b0);
      checkOutput("abort rdata", l2Rdata, 32'h0);
      @(negedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      applyStimulus("rd 0x10 post reset", 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'h11AA_3344);

      // Zero-latency instance: a write followed by a read on the next cycle
      // sees the new data.
      applyStimulusZero("l0 wr 0x10",     1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 32'h0);
      applyStimulusZero("l0 rd 0x10",     1'b1, 1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      applyStimulusZero("l0 wr b1 0x13",  1'b0, 1'b1, 32'h13,  32'h0000_0012, 2'd1, 1'b0, 1'b0, 32'h0);
      applyStimulusZero("l0 rd 0x11",     1'b1, 1'b0, 32'h11,  32'h0,         2'd0, 1'b0, 1'b1, 32'hDEAD_BE12);
      applyStimulusZero("l0 wr cross",    1'b0, 1'b1, 32'h13,  32'h0000_FFFF, 2'd2, 1'b1, 1'b0, 32'h0);
      applyStimulusZero("l0 rd 0x10 b",   1'b1, 1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 1'b1, 32'hDEAD_BE12);
      applyStimulusZero("l0 rd oor",      1'b1, 1'b0, 32'h100, 32'h0,         2'd0, 1'b1, 1'b1, 32'h0);
      applyStimulusZero("l0 idle",        1'b0, 1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 1'b1, 32'hDEAD_BE12);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder for the MEM stage's data-memory request port. It accepts word-aligned reads and sized, possibly unaligned, writes, and stores data big-endian in a word array. It completes each access after a configurable latency and asserts a stall toward the pipeline while an access is in flight. It replaces the zero-latency testbench memory so the pipeline can be exercised under realistic memory timing.

Parameters:
ADDR_BITS, 12, word-index width; capacity is 2^ADDR_BITS words.
LATENCY, 2, cycles an access holds the pipeline (0..15). 0 selects combinational read and single-edge write.
BASE_ADDR, 32'h00000000, byte address mapped to word 0.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
data_address_2DM  input  32  byte address. Reads are word-aligned; writes may be unaligned.
data_write_2DM  input  32  write data, right-justified (low n bytes used)
data_write_size_2DM  input  2  write byte count: 0=4, 1=1, 2=2, 3=3
MemRead_2DM  input  1  read request
MemWrite_2DM  input  1  write request
data_read_fDM  output  32  read data
DM_Stall_OUT  output  1  pipeline must hold the MEM stage
DM_Error_OUT  output  1  one-cycle pulse on an illegal access

Behaviour:
- Byte order: big-endian. Byte offset 0 = bits 31:24, offset 3 = bits 7:0.
- Word index = (address - BASE_ADDR)[ADDR_BITS+1:2].
- Out of range: (address - BASE_ADDR) >= 4*2^ADDR_BITS.
  - Read returns 0.
  - Write is dropped.
  - Error pulses.
- req = MemRead_2DM | MemWrite_2DM.
  - Both asserted: treat as a write and pulse Error.
- FSM, LATENCY >= 1. States: IDLE, WAIT, DONE.
  - IDLE:
    - No req: stall 0.
    - req: latch address, data, size and type; load counter = LATENCY-1.
    - DM_Stall_OUT = 1 combinationally in that same cycle.
    - Next state: WAIT if LATENCY >= 2, else DONE.
  - WAIT: stall 1; decrement counter; go to DONE when counter reaches 1.
  - DONE: stall 0.
    - Read: data_read_fDM registered at the DONE-entry edge so it is valid throughout DONE.
    - Write: committed at the edge ending DONE.
    - Next state: IDLE.
  - Net effect: stall is high for exactly LATENCY cycles per access. The pipeline advances at the end of DONE, and the next request is seen in IDLE one cycle later.
  - Inputs changing during WAIT/DONE are ignored; latched values are authoritative.
- LATENCY = 0:
  - data_read_fDM = mem[index] combinationally.
  - Write commits at the current rising edge.
  - Stall is constant 0.
  - Error is combinational for that cycle.
- Write merge (read-modify-write of one word):
  - n = size (0→4). o = address[1:0].
  - Bytes o..o+n-1 take data_write_2DM bytes n-1..0, most significant first. Other bytes are unchanged.
  - Example: size 3 at o=1 writes bits 23:0 of the word from data[23:0].
- Illegal write shapes (no write, Error pulses in DONE):
  - o+n > 4 (crosses a word).
  - size 0 with o != 0.
- Reads ignore address[1:0]; the full word is returned.
- data_read_fDM holds its last value outside DONE; it is not updated by writes.
- A repeated identical request (pipeline stalled elsewhere) is re-executed. This is idempotent for reads and for writes.
- Reset (asynchronous, any state):
  - State IDLE, DM_Stall_OUT 0, DM_Error_OUT 0, data_read_fDM 0, counter 0.
  - An in-flight write is dropped.
  - Memory array is not cleared.
- Memory contents are undefined until written; the bench preloads by writes.

Test Plan:
- LATENCY=2: write 0x11223344 @0x10 size 0 → stall high 2 cycles, no Error. Then read @0x10 → stall 2 cycles; data_read_fDM = 0x11223344 in DONE.
- After the above: write size 1 @0x11 data 0x000000AA → read @0x12 returns 0x11AA3344 (address[1:0] ignored).
- Preload 0x01020304 @0x14:
  - Size 3 @0x15 data 0x00BBCCDD → read 0x01BBCCDD.
  - Then size 2 @0x14 data 0x0000EEFF → read 0xEEFFCCDD.
- Illegal shapes, each → DM_Error_OUT one-cycle pulse in DONE; word unchanged on readback:
  - size 2 @0x13
  - size 0 @0x16
  - address 4*2^ADDR_BITS
- Assert RESET low during WAIT of a write 0xFFFFFFFF @0x10 → stall drops immediately, data_read_fDM = 0. Readback after reset shows the old word.
- LATENCY=0 build:
  - Stall never asserted.
  - Read @0x10 combinationally equals stored word.
  - Back-to-back write then read of the same address in consecutive cycles returns the new data.
